// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch-address generator for the MIPS32 instruction ROM.
//            Optional macro PC_MISALIGN_EXC_EN enables misaligned-fetch traps.
// Revision : 1.0  initial release
// ============================================================================
module pc_gen #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              pend_valid,
   output logic              fetch_adel
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              ce_q, ce_d;
   logic              adel_q, adel_d;
   logic              w_load;
   logic [ADDR_W-1:0] w_load_addr;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_addr_d = pend_addr_q;
      ce_d        = 1'b1;
      adel_d      = adel_q;
      w_load      = 1'b0;
      w_load_addr = pc_q;

      case (state_q)
         S_RST: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (flush) begin
               w_load      = 1'b1;
               w_load_addr = new_pc;
            end else if (adel_q) begin
               pc_d = pc_q;
            end else if (stall_if) begin
               if (branch_flag) begin
                  pend_addr_d = branch_target;
                  state_d     = S_HOLD;
               end
            end else if (branch_flag) begin
               w_load      = 1'b1;
               w_load_addr = branch_target;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         S_HOLD: begin
            if (flush) begin
               w_load      = 1'b1;
               w_load_addr = new_pc;
               state_d     = S_RUN;
            end else if (stall_if) begin
               if (branch_flag) begin
                  pend_addr_d = branch_target;
               end
            end else begin
               // A redirect arriving on the release cycle is the newest one.
               w_load      = 1'b1;
               w_load_addr = branch_flag ? branch_target : pend_addr_q;
               state_d     = S_RUN;
            end
         end
         default: begin
            state_d = S_RST;
         end
      endcase

`ifdef PC_MISALIGN_EXC_EN
      if (w_load) begin
         pc_d   = w_load_addr;
         adel_d = (w_load_addr[1:0] != 2'b00);
      end
      ce_d = ~adel_d;
`else
      if (w_load) begin
         pc_d = w_load_addr & ~32'h3;
      end
      adel_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RST;
         pc_q        <= RESET_VEC;
         pend_addr_q <= '0;
         ce_q        <= 1'b0;
         adel_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_addr_q <= pend_addr_d;
         ce_q        <= ce_d;
         adel_q      <= adel_d;
      end
   end

   assign pc         = pc_q;
   assign ce         = ce_q;
   assign pend_valid = (state_q == S_HOLD);
   assign fetch_adel = adel_q;

endmodule
`default_nettype wire
